// File: rtl/bz_serializer_if.sv
// bz_serializer_if
//   Valid/acknowledge word channel between the BrainDrop core and the
//   serializer. The core drives the word (d) and its valid (v); the
//   serializer answers with the acknowledge (a). A word moves on a rising
//   clock edge where v && a.
//
//   Signals:
//     d  [W-1:0]  word from the core
//     v           word valid (core -> serializer)
//     a           word acknowledge (serializer -> core)
//
//   Modports:
//     master  core side       (drives d, v; samples a)
//     slave   serializer side (samples d, v; drives a)
interface bz_serializer_if #(
  parameter int W = 32
);
  logic [W-1:0] d;
  logic         v;
  logic         a;

  modport master (output d, output v, input a);
  modport slave  (input d, input v, output a);
endinterface

// File: rtl/bz_serializer.sv
// bz_serializer
//   Packs 32-bit core words into 11-bit router flits. Every word becomes a
//   header flit carrying the route, then three data flits carrying the low
//   30 bits of the word, most significant slice first. The last flit of a
//   packet has the tail bit (bit 10) set. The top two code bits of the word
//   are not routed; a nonzero value there only sets the sticky bad_code flag.
//
//   Ports:
//     clk            rising-edge clock
//     reset          asynchronous active-high reset
//     PC_in_channel  word channel from the core (slave side: d, v in; a out)
//     route          destination route, captured with the word
//     isfull         downstream FIFO full; stalls the flit stream
//     data_out       flit {tail, payload[9:0]}
//     wrreq          FIFO write request
//     pkt_count      completed packets, wraps at 2^16
//     bad_code       sticky: some accepted word had d[31:30] != 0
module bz_serializer #(
  parameter int NPCcode  = 8,
  parameter int NPCdata  = 24,
  parameter int NPCroute = 10
) (
  input  logic                clk,
  input  logic                reset,
  bz_serializer_if.slave      PC_in_channel,
  input  logic [NPCroute-1:0] route,
  input  logic                isfull,
  output logic [NPCroute:0]   data_out,
  output logic                wrreq,
  output logic [15:0]         pkt_count,
  output logic                bad_code
);

  localparam int NW = NPCcode + NPCdata;  // full core word width
  localparam int NB = 3 * NPCroute;       // routed data bits (three flits)

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_D0,
    S_D1,
    S_D2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NB-1:0]       r_word;
  logic [NPCroute-1:0] r_rt;
  logic [15:0]         r_pkt_count;
  logic                r_bad_code;
  logic                w_ready;
  logic                w_xfer;
  logic                w_last_done;

  // Ready while idle, or while the final flit is leaving this cycle so the
  // next word follows without a bubble. Forced low during reset.
  assign w_ready     = !reset && ((r_state == S_IDLE) || (r_state == S_D2 && !isfull));
  assign w_xfer      = PC_in_channel.v && w_ready;
  assign w_last_done = (r_state == S_D2) && !isfull;

  assign PC_in_channel.a = w_ready;
  assign pkt_count       = r_pkt_count;
  assign bad_code        = r_bad_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_rt        <= '0;
      r_pkt_count <= '0;
      r_bad_code  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_xfer) begin
        r_word     <= PC_in_channel.d[NB-1:0];
        r_rt       <= route;
        r_bad_code <= r_bad_code | (|PC_in_channel.d[NW-1:NB]);
      end
      if (w_last_done) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    data_out     = '0;
    wrreq        = (r_state != S_IDLE) && !isfull;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) w_state_next = S_HDR;
      end
      S_HDR: begin
        data_out = {1'b0, r_rt};
        if (!isfull) w_state_next = S_D0;
      end
      S_D0: begin
        data_out = {1'b0, r_word[3*NPCroute-1:2*NPCroute]};
        if (!isfull) w_state_next = S_D1;
      end
      S_D1: begin
        data_out = {1'b0, r_word[2*NPCroute-1:NPCroute]};
        if (!isfull) w_state_next = S_D2;
      end
      S_D2: begin
        data_out = {1'b1, r_word[NPCroute-1:0]};
        if (!isfull) w_state_next = w_xfer ? S_HDR : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bz_serializer.sv
// tb_bz_serializer
//   Directed scenarios followed by randomized traffic. A queue model of the
//   pending flits predicts every output on every falling edge; literal flit
//   values pin the model for the directed words.
module tb_bz_serializer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  route = '0;
  logic        isfull = 1'b0;
  logic [10:0] data_out;
  logic        wrreq;
  logic [15:0] pkt_count;
  logic        bad_code;

  bz_serializer_if ch ();

  bz_serializer dut (
    .clk          (clk),
    .reset        (reset),
    .PC_in_channel(ch),
    .route        (route),
    .isfull       (isfull),
    .data_out     (data_out),
    .wrreq        (wrreq),
    .pkt_count    (pkt_count),
    .bad_code     (bad_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: flits still owed to the FIFO, in order, plus counters.
  logic [10:0] m_q[$];
  logic [15:0] m_pkt = '0;
  logic        m_bad = 1'b0;

  // Logs of what the DUT actually did, for the directed checks.
  logic [10:0] wr_data[$];
  int          wr_cyc[$];
  int          hs_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : chk
    logic [10:0] e_data;
    logic        e_wr;
    logic        e_a;
    if (reset) begin
      m_q.delete();
      m_pkt = '0;
      m_bad = 1'b0;
    end
    e_wr   = !reset && (m_q.size() > 0) && !isfull;
    e_data = (m_q.size() > 0) ? m_q[0] : 11'd0;
    e_a    = !reset && ((m_q.size() == 0) || (m_q.size() == 1 && !isfull));
    check("wrreq", 32'(wrreq), 32'(e_wr));
    check("data_out", 32'(data_out), 32'(e_data));
    check("ack", 32'(ch.a), 32'(e_a));
    check("pkt_count", 32'(pkt_count), 32'(m_pkt));
    check("bad_code", 32'(bad_code), 32'(m_bad));
    if (wrreq) begin
      wr_data.push_back(data_out);
      wr_cyc.push_back(cyc);
    end
    if (ch.v && ch.a) hs_cyc.push_back(cyc);
    if (!reset) begin
      if (e_wr) begin
        if (m_q[0][10]) m_pkt = m_pkt + 16'd1;
        void'(m_q.pop_front());
      end
      if (ch.v && e_a) begin
        m_q.push_back({1'b0, route});
        m_q.push_back({1'b0, ch.d[29:20]});
        m_q.push_back({1'b0, ch.d[19:10]});
        m_q.push_back({1'b1, ch.d[9:0]});
        m_bad = m_bad | (ch.d[31:30] != 2'b00);
      end
    end
    cyc++;
  end

  task automatic clear_logs();
    wr_data.delete();
    wr_cyc.delete();
    hs_cyc.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic put_word(input logic [31:0] d, input logic [9:0] r, input bit keep_v);
    int n0 = hs_cyc.size();
    int k = 0;
    ch.v  = 1'b1;
    ch.d  = d;
    route = r;
    while (hs_cyc.size() == n0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("accept_timeout", 32'(hs_cyc.size() > n0), 32'd1);
    @(posedge clk);
    #1;
    if (!keep_v) ch.v = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int k = 0;
    while (wr_data.size() < n && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("write_timeout", 32'(wr_data.size() >= n), 32'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int          p0;
    logic [11:0] tails;
    ch.v = 1'b0;
    ch.d = '0;
    step(3);
    check("reset_ack", 32'(ch.a), 32'd0);
    check("reset_pkt", 32'(pkt_count), 32'd0);
    reset = 1'b0;
    step(1);

    // Single word, no backpressure.
    clear_logs();
    put_word(32'h0ABC_DEF1, 10'h155, 1'b0);
    wait_writes(4);
    check("single_f0", 32'(wr_data[0]), 32'h155);
    check("single_f1", 32'(wr_data[1]), 32'h0AB);
    check("single_f2", 32'(wr_data[2]), 32'h337);
    check("single_f3", 32'(wr_data[3]), 32'h6F1);
    for (int i = 0; i < 4; i++) check("single_lat", 32'(wr_cyc[i] - hs_cyc[0]), 32'(i + 1));
    step(1);
    check("single_pkt", 32'(pkt_count), 32'd1);
    check("single_bad", 32'(bad_code), 32'd0);

    // Three words under continuous valid.
    step(2);
    clear_logs();
    put_word(32'h1111_1111, 10'h001, 1'b1);
    put_word(32'h2222_2222, 10'h002, 1'b1);
    put_word(32'h3333_3333, 10'h003, 1'b0);
    wait_writes(12);
    check("cont_acc1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd4);
    check("cont_acc2", 32'(hs_cyc[2] - hs_cyc[0]), 32'd8);
    check("cont_span", 32'(wr_cyc[11] - wr_cyc[0]), 32'd11);
    check("cont_first", 32'(wr_cyc[0] - hs_cyc[0]), 32'd1);
    tails = '0;
    for (int i = 0; i < 12; i++) tails[i] = wr_data[i][10];
    check("cont_tails", 32'(tails), 32'h888);

    // Backpressure in D0 and again in D2.
    step(3);
    clear_logs();
    p0 = int'(pkt_count);
    put_word(32'h0ABC_DEF1, 10'h155, 1'b0);
    step(1);          // header written, now in D0
    isfull = 1'b1;
    step(3);
    isfull = 1'b0;
    step(2);          // D0 and D1 written, now in D2
    isfull = 1'b1;
    step(3);
    check("stall_pkt_hold", 32'(pkt_count), 32'(p0));
    check("stall_wr_count", 32'(wr_data.size()), 32'd3);
    isfull = 1'b0;
    wait_writes(4);
    step(1);
    check("stall_pkt_inc", 32'(pkt_count), 32'(p0 + 1));
    check("stall_f0", 32'(wr_data[0]), 32'h155);
    check("stall_f1", 32'(wr_data[1]), 32'h0AB);
    check("stall_f2", 32'(wr_data[2]), 32'h337);
    check("stall_f3", 32'(wr_data[3]), 32'h6F1);
    step(3);
    check("stall_no_dup", 32'(wr_data.size()), 32'd4);

    // Nonzero code bits.
    clear_logs();
    put_word(32'hC000_0001, 10'h0F0, 1'b0);
    wait_writes(4);
    check("bad_f0", 32'(wr_data[0]), 32'h0F0);
    check("bad_f1", 32'(wr_data[1]), 32'h000);
    check("bad_f2", 32'(wr_data[2]), 32'h000);
    check("bad_f3", 32'(wr_data[3]), 32'h401);
    step(1);
    check("bad_set", 32'(bad_code), 32'd1);
    put_word(32'h0000_0005, 10'h0F1, 1'b0);
    wait_writes(8);
    step(1);
    check("bad_sticky", 32'(bad_code), 32'd1);

    // Reset in D1, then a fresh packet.
    clear_logs();
    put_word(32'h0000_0777, 10'h333, 1'b0);
    step(2);          // header and D0 written, now in D1
    reset = 1'b1;
    #1;
    check("rst_ack", 32'(ch.a), 32'd0);
    check("rst_wrreq", 32'(wrreq), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    step(2);
    reset = 1'b0;
    step(1);
    clear_logs();
    put_word(32'h1234_5678, 10'h2A5, 1'b0);
    wait_writes(4);
    check("rst_f0", 32'(wr_data[0]), 32'h2A5);
    check("rst_f1", 32'(wr_data[1]), 32'h123);
    check("rst_f2", 32'(wr_data[2]), 32'h115);
    check("rst_f3", 32'(wr_data[3]), 32'h678);
    step(1);
    check("rst_pkt", 32'(pkt_count), 32'd1);

    // Randomized traffic against the model.
    repeat (4000) begin
      ch.v   = ($urandom_range(0, 3) != 0);
      ch.d   = {(($urandom_range(0, 15) == 0) ? 2'b11 : 2'b00), 30'($urandom)};
      route  = 10'($urandom);
      isfull = ($urandom_range(0, 3) == 0);
      reset  = ($urandom_range(0, 399) == 0);
      step(1);
    end
    ch.v   = 1'b0;
    isfull = 1'b0;
    reset  = 1'b0;
    step(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
